character_motion_ctrl: RTL

CHARACTER_MOTION_CTRL -- requirements
Module: character_motion_ctrl

---
 rtl/motion_pkg.sv | 22 ++
 rtl/shot_channel.sv | 59 +++++
 rtl/character_motion_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared position/velocity types, screen defaults and horizontal wrap
package motion_pkg;

    typedef logic [9:0]         pos_t;
    typedef logic signed [10:0] vel_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    // Folds a one-step overshoot back onto the screen in either direction.
    function automatic pos_t wrap_x(input vel_t r, input vel_t w);
        vel_t t;
        if (r >= w)
            t = r - w;
        else if (r[10])
            t = r + w;
        else
            t = r;
        return t[9:0];
    endfunction

endpackage

// File: rtl/shot_channel.sv
// rtl/shot_channel.sv - one projectile slot; SHOT_AIM_EN adds a latched horizontal drift
module shot_channel
    import motion_pkg::*;
#(
`ifdef SHOT_AIM_EN
    parameter int SCREEN_W   = DEF_SCREEN_W,
`endif
    parameter int SHOT_SPEED = 7
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        load,
    input  logic        step,
    input  logic [9:0]  load_x,
    input  logic [9:0]  load_y,
`ifdef SHOT_AIM_EN
    input  logic [10:0] load_dx,
`endif
    output logic        valid,
    output logic [9:0]  x,
    output logic [9:0]  y
);

    localparam pos_t SPEED = pos_t'(SHOT_SPEED);

`ifdef SHOT_AIM_EN
    localparam vel_t SCR_W = vel_t'(SCREEN_W);
    vel_t dx;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
`ifdef SHOT_AIM_EN
            dx    <= '0;
`endif
        end else if (load) begin
            valid <= 1'b1;
            x     <= load_x;
            y     <= load_y;
`ifdef SHOT_AIM_EN
            dx    <= $signed(load_dx);
`endif
        end else if (step && valid) begin
            // Expire rather than step past the top edge.
            if (y < SPEED) begin
                valid <= 1'b0;
            end else begin
                y <= y - SPEED;
`ifdef SHOT_AIM_EN
                x <= wrap_x($signed({1'b0, x}) + dx, SCR_W);
`endif
            end
        end
    end

endmodule

// File: rtl/character_motion_ctrl.sv
// rtl/character_motion_ctrl.sv - bouncing character with wrap-around walk and projectile pool (SHOT_AIM_EN: aimed shots)
module character_motion_ctrl
    import motion_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int CHAR_SIZE  = 12,
    parameter int GRAVITY    = 1,
    parameter int JUMP_VEL   = 12,
    parameter int MAX_FALL   = 8,
    parameter int X_SPEED    = 2,
    parameter int NUM_SHOTS  = 4,
    parameter int SHOT_SPEED = 7
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    run,
    input  logic                    move_left,
    input  logic                    move_right,
    input  logic                    fire,
    input  logic                    land,
    output logic [9:0]              char_x,
    output logic [9:0]              char_y,
    output logic [9:0]              char_vy,
    output logic [NUM_SHOTS*10-1:0] shot_x,
    output logic [NUM_SHOTS*10-1:0] shot_y,
    output logic [NUM_SHOTS-1:0]    shot_valid,
    output logic                    shot_busy
);

    localparam vel_t GRAV       = vel_t'(GRAVITY);
    localparam vel_t MAXF       = vel_t'(MAX_FALL);
    localparam vel_t JUMP       = vel_t'(JUMP_VEL);
    localparam vel_t XS         = vel_t'(X_SPEED);
    localparam vel_t SCR_W      = vel_t'(SCREEN_W);
    localparam vel_t FLOOR_EDGE = vel_t'(SCREEN_H - 1);
    localparam vel_t FLOOR_V    = vel_t'(SCREEN_H - 1 - CHAR_SIZE);
    localparam vel_t CEIL_V     = vel_t'(CHAR_SIZE);
    localparam pos_t FLOOR_POS  = pos_t'(SCREEN_H - 1 - CHAR_SIZE);
    localparam pos_t CEIL_POS   = pos_t'(CHAR_SIZE);
    localparam pos_t START_X    = pos_t'(SCREEN_W / 2);
    localparam pos_t START_Y    = pos_t'(SCREEN_H / 2);

    pos_t x_q, y_q, y_new;
    vel_t vy_q, vy_new, vy_sum, vy_next, y_next, x_sum, dx;
    logic fire_q, fire_edge, found;
    logic [NUM_SHOTS-1:0] load_vec;

    always_comb begin
        dx = '0;
        if (move_right && !move_left)
            dx = XS;
        else if (move_left && !move_right)
            dx = -XS;
        x_sum = $signed({1'b0, x_q}) + dx;

        vy_sum  = vy_q + GRAV;
        vy_next = (vy_sum > MAXF) ? MAXF : vy_sum;
        y_next  = $signed({1'b0, y_q}) + vy_next;

        vy_new = vy_next;
        y_new  = y_next[9:0];
        // Platform contact only counts on the way down.
        if (!vy_next[10] && ((y_next + CEIL_V >= FLOOR_EDGE) || land)) begin
            y_new  = (y_next > FLOOR_V) ? FLOOR_POS : y_next[9:0];
            vy_new = -JUMP;
        end else if (y_next < CEIL_V) begin
            y_new  = CEIL_POS;
            vy_new = '0;
        end
    end

    assign fire_edge = run && fire && !fire_q;

    // A channel expiring this frame still reads valid, so it is not reused until the next one.
    always_comb begin
        load_vec = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!found && !shot_valid[i]) begin
                load_vec[i] = fire_edge;
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            x_q    <= START_X;
            y_q    <= START_Y;
            vy_q   <= '0;
            fire_q <= 1'b0;
        end else if (run) begin
            x_q    <= wrap_x(x_sum, SCR_W);
            y_q    <= y_new;
            vy_q   <= vy_new;
            fire_q <= fire;
        end
    end

    for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_shot
        shot_channel #(
`ifdef SHOT_AIM_EN
            .SCREEN_W  (SCREEN_W),
`endif
            .SHOT_SPEED(SHOT_SPEED)
        ) u_chan (
            .frame_clk(frame_clk),
            .Reset    (Reset),
            .load     (load_vec[i]),
            .step     (run),
            .load_x   (x_q),
            .load_y   (y_q - CEIL_POS),
`ifdef SHOT_AIM_EN
            .load_dx  (dx),
`endif
            .valid    (shot_valid[i]),
            .x        (shot_x[i*10 +: 10]),
            .y        (shot_y[i*10 +: 10])
        );
    end

    assign char_x    = x_q;
    assign char_y    = y_q;
    assign char_vy   = vy_q[9:0];
    assign shot_busy = &shot_valid;

endmodule
